// File: rtl/key_debounce.sv
// Two-key debouncer: each raw key is polarity-corrected, synchronized and filtered by
// its own debounce FSM; key_add additionally auto-repeats while held.
module key_debounce #(
  parameter int DB_CYCLES      = 1024,
  parameter int REPEAT_DELAY   = 32768,
  parameter int REPEAT_PERIOD  = 8192,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic key_mode,
  input  logic key_add,
  output logic key_mode_down,
  output logic key_add_down,
  output logic key_mode_negedge,
  output logic key_add_negedge,
  output logic key_mode_level,
  output logic key_add_level
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
  localparam logic [15:0] REP_FIRST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] REP_NEXT  = 16'(REPEAT_PERIOD - 1);

  logic [1:0] raw_key;
  logic [1:0] down_vec;
  logic [1:0] neg_vec;
  logic [1:0] level_vec;

  // Bit 0 is the mode key, bit 1 the add key; both become pressed = 1 here.
  assign raw_key = {key_add, key_mode} ^ {2{KEY_ACTIVE_LOW}};

  for (genvar g = 0; g < 2; g++) begin : gen_ch
    logic        sync_a;
    logic        s;
    logic [1:0]  state;
    logic [15:0] cnt;
    logic        down_r;
    logic        neg_r;
    logic        level_r;
    logic        press_done;
    logic        release_done;
    logic        rep_hit;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_a <= 1'b0;
        s      <= 1'b0;
      end else begin
        sync_a <= raw_key[g];
        s      <= sync_a;
      end
    end

    assign press_done   = (state == PRESS_WAIT)   &&  s && (cnt == DB_LAST);
    assign release_done = (state == RELEASE_WAIT) && !s && (cnt == DB_LAST);

    // A bounce back during either wait state abandons the window without a pulse.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (s) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s)              state <= IDLE;
            else if (press_done) state <= PRESSED;
            else                 cnt   <= cnt + 16'd1;
          end
          PRESSED: begin
            if (!s) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (s)                 state <= PRESSED;
            else if (release_done) state <= IDLE;
            else                   cnt   <= cnt + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        down_r  <= 1'b0;
        neg_r   <= 1'b0;
        level_r <= 1'b0;
      end else begin
        down_r <= press_done | rep_hit;
        neg_r  <= release_done;
        if (press_done)        level_r <= 1'b1;
        else if (release_done) level_r <= 1'b0;
      end
    end

    if (g == 1) begin : gen_repeat
      logic [15:0] rep_cnt;
      logic        rep_started;

      // Counts only while stably PRESSED, so release glitches just pause the schedule.
      assign rep_hit = (state == PRESSED) &&
                       (rep_cnt == (rep_started ? REP_NEXT : REP_FIRST));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          rep_cnt     <= '0;
          rep_started <= 1'b0;
        end else if (press_done) begin
          rep_cnt     <= '0;
          rep_started <= 1'b0;
        end else if (state == PRESSED) begin
          if (rep_hit) begin
            rep_cnt     <= '0;
            rep_started <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 16'd1;
          end
        end
      end
    end else begin : gen_no_repeat
      assign rep_hit = 1'b0;
    end

    assign down_vec[g]  = down_r;
    assign neg_vec[g]   = neg_r;
    assign level_vec[g] = level_r;
  end

  assign key_mode_down    = down_vec[0];
  assign key_add_down     = down_vec[1];
  assign key_mode_negedge = neg_vec[0];
  assign key_add_negedge  = neg_vec[1];
  assign key_mode_level   = level_vec[0];
  assign key_add_level    = level_vec[1];

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: one active-high and one active-low instance driven with the
// same logical presses, both compared every cycle against a run-length reference model.
module tb_key_debounce;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  typedef int intQ[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mode0 = 1'b0, add0 = 1'b0, mode1 = 1'b1, add1 = 1'b1;

  logic m0Down, a0Down, m0Neg, a0Neg, m0Lvl, a0Lvl;
  logic m1Down, a1Down, m1Neg, a1Neg, m1Lvl, a1Lvl;

  int checkCount = 0;
  int passCount  = 0;
  int edgeNum    = 0;
  int phaseBase  = 0;

  // Reference model: synchronizer pipe plus a count of cycles the synchronized level
  // has disagreed with the debounced level, and a held-time count for repeats.
  bit sa[2], sb[2], deb[2], expDown[2], expNeg[2];
  int run[2], held[2], nextRep[2];

  intQ logModeDown, logModeNeg, logAddDown, logAddNeg;
  intQ noneQ;

  bit patB[8] = '{1, 1, 0, 1, 1, 0, 1, 0};
  int remM = 0, remA = 0;
  bit lvM = 1'b0, lvA = 1'b0;

  key_debounce #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .KEY_ACTIVE_LOW(1'b0)) dut0 (
    .clock(clock), .reset(reset), .key_mode(mode0), .key_add(add0),
    .key_mode_down(m0Down), .key_add_down(a0Down),
    .key_mode_negedge(m0Neg), .key_add_negedge(a0Neg),
    .key_mode_level(m0Lvl), .key_add_level(a0Lvl)
  );

  key_debounce #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .KEY_ACTIVE_LOW(1'b1)) dut1 (
    .clock(clock), .reset(reset), .key_mode(mode1), .key_add(add1),
    .key_mode_down(m1Down), .key_add_down(a1Down),
    .key_mode_negedge(m1Neg), .key_add_negedge(a1Neg),
    .key_mode_level(m1Lvl), .key_add_level(a1Lvl)
  );

  always #5 clock = ~clock;

  task automatic modelReset();
    for (int ch = 0; ch < 2; ch++) begin
      sa[ch] = 0; sb[ch] = 0; deb[ch] = 0; expDown[ch] = 0; expNeg[ch] = 0;
      run[ch] = 0; held[ch] = 0; nextRep[ch] = 0;
    end
  endtask

  task automatic modelEdge(input bit m, input bit a);
    bit in, s;
    for (int ch = 0; ch < 2; ch++) begin
      expDown[ch] = 0;
      expNeg[ch]  = 0;
      if (reset) begin
        in = (ch == 0) ? m : a;
        s = sb[ch];
        sb[ch] = sa[ch];
        sa[ch] = in;
        if (deb[ch] && run[ch] == 0) begin
          held[ch]++;
          if (ch == 1 && held[ch] == nextRep[ch]) begin
            expDown[ch] = 1;
            nextRep[ch] += RP;
          end
        end
        if (s != deb[ch]) run[ch]++;
        else run[ch] = 0;
        if (run[ch] == DB + 1) begin
          deb[ch] = s;
          run[ch] = 0;
          if (s) begin
            expDown[ch] = 1;
            held[ch] = 0;
            nextRep[ch] = RD;
          end else begin
            expNeg[ch] = 1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [5:0] exp, got0, got1;
    exp  = {expDown[0], expNeg[0], deb[0], expDown[1], expNeg[1], deb[1]};
    got0 = {m0Down, m0Neg, m0Lvl, a0Down, a0Neg, a0Lvl};
    got1 = {m1Down, m1Neg, m1Lvl, a1Down, a1Neg, a1Lvl};
    checkCount++;
    assert (got0 === exp) passCount++;
    else $error("FAIL outputs_active_high edge=%0d observed=%b expected=%b", edgeNum, got0, exp);
    checkCount++;
    assert (got1 === exp) passCount++;
    else $error("FAIL outputs_active_low edge=%0d observed=%b expected=%b", edgeNum, got1, exp);
    if (got0[5] === 1'b1) logModeDown.push_back(edgeNum - phaseBase);
    if (got0[4] === 1'b1) logModeNeg.push_back(edgeNum - phaseBase);
    if (got0[2] === 1'b1) logAddDown.push_back(edgeNum - phaseBase);
    if (got0[1] === 1'b1) logAddNeg.push_back(edgeNum - phaseBase);
  endtask

  task automatic applyStimulus(input bit m, input bit a);
    mode0 = m;  add0 = a;
    mode1 = ~m; add1 = ~a;
    @(posedge clock);
    edgeNum++;
    modelEdge(m, a);
    #1;
    checkOutput();
  endtask

  task automatic setReset(input logic v);
    reset = v;
    if (!v) modelReset();
    #1;
    checkOutput();
  endtask

  task automatic startPhase();
    phaseBase = edgeNum;
    logModeDown.delete();
    logModeNeg.delete();
    logAddDown.delete();
    logAddNeg.delete();
  endtask

  task automatic checkLog(input string tag, input intQ got, input intQ want);
    checkCount++;
    assert (got.size() === want.size()) passCount++;
    else $error("FAIL %s_count observed=%0d expected=%0d", tag, got.size(), want.size());
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) begin
        checkCount++;
        assert (got[i] === want[i]) passCount++;
        else $error("FAIL %s_edge[%0d] observed=%0d expected=%0d", tag, i, got[i], want[i]);
      end
    end
  endtask

  function automatic int pickRun();
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(20, 60));
    return int'($urandom_range(1, 7));
  endfunction

  initial begin
    modelReset();
    #1;
    setReset(1'b0);
    repeat (3) applyStimulus(0, 0);
    setReset(1'b1);
    repeat (5) applyStimulus(0, 0);

    // Clean mode press held 40 cycles, then released
    startPhase();
    repeat (40) applyStimulus(1, 0);
    repeat (15) applyStimulus(0, 0);
    checkLog("mode_down", logModeDown, '{7});
    checkLog("mode_negedge", logModeNeg, '{47});
    checkLog("mode_phase_add_down", logAddDown, noneQ);

    // Short add bounces only
    startPhase();
    for (int i = 0; i < 8; i++) applyStimulus(0, patB[i]);
    repeat (15) applyStimulus(0, 0);
    checkLog("bounce_add_down", logAddDown, noneQ);
    checkLog("bounce_add_negedge", logAddNeg, noneQ);

    // Long add hold with auto-repeat
    startPhase();
    repeat (61) applyStimulus(0, 1);
    repeat (15) applyStimulus(0, 0);
    checkLog("repeat_add_down", logAddDown, '{7, 27, 35, 43, 51, 59});
    checkLog("repeat_add_negedge", logAddNeg, '{68});

    // Two-cycle release glitch at edge 30 pauses the repeat schedule
    startPhase();
    repeat (29) applyStimulus(0, 1);
    repeat (2) applyStimulus(0, 0);
    repeat (29) applyStimulus(0, 1);
    repeat (15) applyStimulus(0, 0);
    checkLog("glitch_add_down", logAddDown, '{7, 27, 37, 45, 53, 61});
    checkLog("glitch_add_negedge", logAddNeg, '{67});

    // Reset in the middle of a mode press, key still held at release
    startPhase();
    repeat (4) applyStimulus(1, 0);
    setReset(1'b0);
    repeat (5) applyStimulus(1, 0);
    setReset(1'b1);
    repeat (21) applyStimulus(1, 0);
    repeat (15) applyStimulus(0, 0);
    checkLog("reset_mode_down", logModeDown, '{16});
    checkLog("reset_mode_negedge", logModeNeg, '{37});

    // Both keys together
    startPhase();
    repeat (12) applyStimulus(1, 1);
    repeat (15) applyStimulus(0, 0);
    checkLog("both_mode_down", logModeDown, '{7});
    checkLog("both_add_down", logAddDown, '{7});
    checkLog("both_mode_negedge", logModeNeg, '{19});
    checkLog("both_add_negedge", logAddNeg, '{19});

    // Random press/release/bounce traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (remM <= 0) begin lvM = !lvM; remM = pickRun(); end
      if (remA <= 0) begin lvA = !lvA; remA = pickRun(); end
      if ($urandom_range(0, 199) == 0) begin
        setReset(1'b0);
        applyStimulus(lvM, lvA);
        applyStimulus(lvM, lvA);
        setReset(1'b1);
      end
      applyStimulus(lvM, lvA);
      remM--;
      remA--;
    end
    repeat (20) applyStimulus(0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
